// File: rtl/ace_io_pkg.sv
// Shared definitions for the board I/O peripheral: register offsets,
// bus handshake states and seven-segment encoding.
package ace_io_pkg;

    localparam logic [2:0] OFF_HEX_DATA = 3'd0;
    localparam logic [2:0] OFF_HEX_EN   = 3'd1;
    localparam logic [2:0] OFF_LEDR     = 3'd2;
    localparam logic [2:0] OFF_LEDG     = 3'd3;
    localparam logic [2:0] OFF_SW       = 3'd4;
    localparam logic [2:0] OFF_KEY      = 3'd5;
    localparam logic [2:0] OFF_KEY_EDGE = 3'd6;
    localparam logic [2:0] OFF_RSVD     = 3'd7;

    localparam logic [6:0] SEG_BLANK = 7'h7F;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RESP = 2'd1,
        ST_HOLD = 2'd2
    } bus_state_t;

    // Active-low segments, bit 0 = segment a ... bit 6 = segment g.
    function automatic logic [6:0] seg7(input logic [3:0] nib);
        logic [6:0] seg;
        case (nib)
            4'h0: seg = 7'h40;
            4'h1: seg = 7'h79;
            4'h2: seg = 7'h24;
            4'h3: seg = 7'h30;
            4'h4: seg = 7'h19;
            4'h5: seg = 7'h12;
            4'h6: seg = 7'h02;
            4'h7: seg = 7'h78;
            4'h8: seg = 7'h00;
            4'h9: seg = 7'h10;
            4'hA: seg = 7'h08;
            4'hB: seg = 7'h03;
            4'hC: seg = 7'h46;
            4'hD: seg = 7'h21;
            4'hE: seg = 7'h06;
            default: seg = 7'h0E;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/key_debounce.sv
// Synchronises one active-low push-button and accepts a new level only after
// it has been held for DEBOUNCE_CYCLES consecutive cycles.
module key_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 250000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw_n,
    output logic level,
    output logic rise
);

    localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1;
    logic             sync2;
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1 <= 1'b1;
            sync2 <= 1'b1;
            level <= 1'b0;
            rise  <= 1'b0;
            cnt   <= '0;
        end else begin
            sync1 <= raw_n;
            sync2 <= sync1;
            rise  <= 1'b0;
            if ((!sync2) == level) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                level <= ~level;
                rise  <= ~level;
                cnt   <= '0;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/board_io_ctrl.sv
// Memory-mapped board I/O: seven-segment digits, LEDs, synchronised switches,
// debounced keys with sticky press events, behind a one-ack-per-request bus.
module board_io_ctrl
    import ace_io_pkg::*;
#(
    parameter int unsigned HEX_DIGITS      = 8,
    parameter int unsigned LEDR_W          = 18,
    parameter int unsigned LEDG_W          = 9,
    parameter int unsigned SW_W            = 10,
    parameter int unsigned KEY_W           = 4,
    parameter logic [31:0] BASE_ADDR       = 32'hFFFF_0000,
    parameter int unsigned DEBOUNCE_CYCLES = 250000
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    mem_read,
    input  logic                    mem_write,
    input  logic [31:0]             mem_addr,
    input  logic [31:0]             mem_write_data,
    output logic [31:0]             mem_read_data,
    output logic                    mem_ack,
    input  logic [SW_W-1:0]         sw,
    input  logic [KEY_W-1:0]        key,
    output logic [HEX_DIGITS*7-1:0] hex_seg,
    output logic [LEDR_W-1:0]       ledr,
    output logic [LEDG_W-1:0]       ledg
);

    localparam int unsigned HEX_W = HEX_DIGITS * 4;

    bus_state_t            state;
    logic [HEX_W-1:0]      hex_data;
    logic [HEX_DIGITS-1:0] hex_en;
    logic [SW_W-1:0]       sw_meta;
    logic [SW_W-1:0]       sw_sync;
    logic [KEY_W-1:0]      key_level;
    logic [KEY_W-1:0]      key_rise;
    logic [KEY_W-1:0]      key_edge;
    logic [KEY_W-1:0]      edge_clr;
    logic [2:0]            offset;
    logic [31:0]           rd_word;
    logic                  sel;
    logic                  req;
    logic                  accept;
    logic                  unused_bits;

    assign sel         = (mem_addr[31:5] == BASE_ADDR[31:5]);
    assign offset      = mem_addr[4:2];
    assign req         = mem_read | mem_write;
    assign accept      = (state == ST_IDLE) && sel && req;
    assign edge_clr    = (accept && mem_write && offset == OFF_KEY_EDGE) ?
                         KEY_W'(mem_write_data) : '0;
    assign unused_bits = ^{mem_addr[1:0], mem_write_data};

    for (genvar k = 0; k < KEY_W; k++) begin : g_key
        key_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_key_debounce (
            .clk  (clk),
            .rst_n(rst_n),
            .raw_n(key[k]),
            .level(key_level[k]),
            .rise (key_rise[k])
        );
    end

    always_comb begin
        rd_word = '0;
        case (offset)
            OFF_HEX_DATA: rd_word = 32'(hex_data);
            OFF_HEX_EN:   rd_word = 32'(hex_en);
            OFF_LEDR:     rd_word = 32'(ledr);
            OFF_LEDG:     rd_word = 32'(ledg);
            OFF_SW:       rd_word = 32'(sw_sync);
            OFF_KEY:      rd_word = 32'(key_level);
            OFF_KEY_EDGE: rd_word = 32'(key_edge);
            default:      rd_word = '0;
        endcase
    end

    // HOLD waits for the request to drop so a held request is acked once.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state         <= ST_IDLE;
            mem_ack       <= 1'b0;
            mem_read_data <= '0;
            hex_data      <= '0;
            hex_en        <= '0;
            ledr          <= '0;
            ledg          <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        state         <= ST_RESP;
                        mem_ack       <= 1'b1;
                        mem_read_data <= mem_write ? 32'h0 : rd_word;
                        if (mem_write) begin
                            case (offset)
                                OFF_HEX_DATA: hex_data <= HEX_W'(mem_write_data);
                                OFF_HEX_EN:   hex_en   <= HEX_DIGITS'(mem_write_data);
                                OFF_LEDR:     ledr     <= LEDR_W'(mem_write_data);
                                OFF_LEDG:     ledg     <= LEDG_W'(mem_write_data);
                                default:      ;
                            endcase
                        end
                    end
                end
                ST_RESP: begin
                    state         <= ST_HOLD;
                    mem_ack       <= 1'b0;
                    mem_read_data <= '0;
                end
                ST_HOLD: begin
                    if (!req) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Sticky key events: a new press overrides a simultaneous clear.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            key_edge <= '0;
            sw_meta  <= '0;
            sw_sync  <= '0;
        end else begin
            key_edge <= (key_edge & ~edge_clr) | key_rise;
            sw_meta  <= sw;
            sw_sync  <= sw_meta;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hex_seg <= '1;
        end else begin
            for (int i = 0; i < HEX_DIGITS; i++) begin
                hex_seg[7*i +: 7] <= hex_en[i] ? seg7(hex_data[4*i +: 4]) : SEG_BLANK;
            end
        end
    end

endmodule
